// File: rtl/rr_arbiter8_disp.sv
// Eight-way round-robin arbiter with bounded hold time, a one-cycle dead gap
// between owners, and a 7-segment display of the current owner index.
module rr_arbiter8_disp #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout,
    output logic [6:0] HEX
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          timeout_q, timeout_d;
    logic [2:0]    winner_s;
    logic          at_limit_s;
    logic          release_s;
    logic [6:0]    hex_s;

    function automatic logic [6:0] seg7(input logic [2:0] digit, input logic valid);
        logic [6:0] seg;
        case (digit)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            3'd7:    seg = 7'b1111000;
            default: seg = 7'b1111111;
        endcase
        return valid ? seg : 7'b1111111;
    endfunction

    // Walk from ptr+7 down to ptr so the last hit is the first requester after ptr.
    always_comb begin
        logic [2:0] idx;
        idx      = 3'd0;
        winner_s = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx      = ptr_q + 3'(i);
            winner_s = req[idx] ? idx : winner_s;
        end
    end

    assign at_limit_s = (hold_cnt_q == HW'(MAX_HOLD - 1));
    assign release_s  = done || !req[gnt_id_q] || !en || at_limit_s;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= '0;
            gnt_q       <= 8'd0;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state and next-grant logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        case (state_q)
            ST_BUSY: begin
                if (release_s) begin
                    state_d     = ST_GAP;
                    ptr_d       = gnt_id_q + 3'd1;
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    // Pulse only when the hold limit is the sole reason.
                    timeout_d   = at_limit_s && !done && req[gnt_id_q] && en;
                end else begin
                    hold_cnt_d  = hold_cnt_q + HW'(1);
                end
            end
            ST_IDLE, ST_GAP: begin
                if (en && (req != 8'd0)) begin
                    state_d     = ST_BUSY;
                    hold_cnt_d  = '0;
                    gnt_d       = 8'd1 << winner_s;
                    gnt_id_d    = winner_s;
                    gnt_valid_d = 1'b1;
                end else begin
                    state_d     = ST_IDLE;
                    gnt_d       = 8'd0;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                gnt_d       = 8'd0;
                gnt_id_d    = 3'd0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // Display decode from the registered owner.
    always_comb begin
        hex_s = seg7(gnt_id_q, gnt_valid_q);
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;
    assign HEX       = hex_s;

endmodule

// File: tb/tb_rr_arbiter8_disp.sv
// Scoreboard bench for rr_arbiter8_disp: a behavioural model predicts each
// cycle's outputs, which are queued on drive and compared after the edge.
module tb_rr_arbiter8_disp;

    localparam int MH = 4;
    localparam logic [6:0] HEX_TAB [0:7] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       v;
        logic       to;
        logic [6:0] hex;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;
    logic [6:0] HEX;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    int       m_state;
    int       m_hold;
    bit [2:0] m_ptr;
    bit [2:0] m_id;
    bit       m_v;
    bit       m_to;

    rr_arbiter8_disp #(.MAX_HOLD(MH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout), .HEX(HEX)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hold = 0; m_ptr = 3'd0; m_id = 3'd0; m_v = 1'b0; m_to = 1'b0;
    endtask

    // One edge of the reference behaviour, from the inputs currently driven.
    task automatic model_step();
        bit rel;
        bit lim;
        bit f;
        int j;
        if (m_state == 1) begin
            lim = (m_hold == MH - 1);
            rel = done || !req[m_id] || !en || lim;
            if (rel) begin
                m_to    = lim && !done && req[m_id] && en;
                m_ptr   = m_id + 3'd1;
                m_id    = 3'd0;
                m_v     = 1'b0;
                m_state = 2;
            end else begin
                m_hold++;
                m_to = 1'b0;
            end
        end else begin
            m_to = 1'b0;
            if (en && req != 8'h00) begin
                f = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    j = (int'(m_ptr) + k) % 8;
                    if (!f && req[j]) begin
                        f    = 1'b1;
                        m_id = 3'(j);
                    end
                end
                m_v = 1'b1; m_hold = 0; m_state = 1;
            end else begin
                m_id = 3'd0; m_v = 1'b0; m_state = 0;
            end
        end
    endtask

    task automatic step();
        exp_t e;
        exp_t o;
        model_step();
        e.gnt = m_v ? (8'b1 << m_id) : 8'h00;
        e.id  = m_id;
        e.v   = m_v;
        e.to  = m_to;
        e.hex = m_v ? HEX_TAB[m_id] : 7'h7F;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check("sb_depth", sb.size(), 32'd1);
        if (sb.size() > 0) begin
            o = sb.pop_front();
            check("gnt", gnt, o.gnt);
            check("gnt_id", gnt_id, o.id);
            check("gnt_valid", gnt_valid, o.v);
            check("timeout", timeout, o.to);
            check("hex", HEX, o.hex);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[$];
        int hi_cnt;
        bit to_seen;
        bit to_found;
        int guard;
        logic [7:0] exp_order [0:7];
        exp_order = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd1};

        rst_n = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 8'h00);
        check("rst_id", gnt_id, 3'd0);
        check("rst_valid", gnt_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_hex", HEX, 7'h7F);
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // First grant and handover after done.
        req = 8'hFF; en = 1'b1;
        step();
        check("t1_gnt0", gnt, 8'h01);
        check("t1_hex0", HEX, 7'b1000000);
        done = 1'b1; step();
        check("t1_dead", gnt, 8'h00);
        done = 1'b0; step();
        check("t1_gnt1", gnt, 8'h02);

        // Full rotation, ptr wraps 7 -> 0.
        for (int c = 0; c < 18; c++) begin
            done = m_v;
            step();
            if (gnt_valid) ids.push_back(int'(gnt_id));
        end
        done = 1'b0;
        check("order_len", (ids.size() >= 8), 1'b1);
        for (int k = 0; k < 8 && k < ids.size(); k++) check("order", ids[k], exp_order[k]);

        // Hold limit on a lone requester 7.
        req = 8'h00;
        repeat (3) step();
        req = 8'h80;
        hi_cnt = 0; to_seen = 1'b0; to_found = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!to_seen && timeout) to_seen = 1'b1;
            else if (!to_seen && gnt == 8'h80) hi_cnt++;
            if (to_seen && !to_found && gnt == 8'h80) to_found = 1'b1;
        end
        check("hold_cycles", hi_cnt, 32'd4);
        check("timeout_seen", to_seen, 1'b1);
        check("regrant7", to_found, 1'b1);

        // Owner 3 drops its request, 4 wins.
        req = 8'h00;
        repeat (3) step();
        req = 8'h08; step();
        check("own3", gnt_id, 3'd3);
        req = 8'h18; step();
        req = 8'h10; step();
        check("drop3_gnt", gnt, 8'h00);
        step();
        check("own4", gnt_id, 3'd4);
        check("own4_hex", HEX, 7'b0011001);
        guard = 0;
        while (m_v && m_hold != MH - 1 && guard < 10) begin
            step();
            guard++;
        end
        done = 1'b1; step();
        check("coincide_no_to", timeout, 1'b0);
        check("coincide_rel", gnt_valid, 1'b0);
        done = 1'b0;

        // Asynchronous reset during grant of 5.
        req = 8'h20; step();
        check("own5", gnt_id, 3'd5);
        rst_n = 1'b0;
        #1;
        check("arst_gnt", gnt, 8'h00);
        check("arst_hex", HEX, 7'h7F);
        check("arst_valid", gnt_valid, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h21; step();
        check("after_rst", gnt_id, 3'd0);

        // Enable gating.
        en = 1'b0; req = 8'hFF;
        repeat (3) step();
        check("en0_hex", HEX, 7'h7F);
        check("en0_gnt", gnt, 8'h00);
        en = 1'b1; req = 8'h04; step();
        check("own2", gnt_id, 3'd2);
        req = 8'hFF; en = 1'b0; step();
        check("en_drop_rel", gnt_valid, 1'b0);
        repeat (2) step();
        check("en_drop_hold", gnt, 8'h00);
        en = 1'b1; step();
        check("ptr3", gnt_id, 3'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
